// File: rtl/my_fetch.sv
// Single-entry instruction fetch stage: registered PC drives a combinational imem,
// the fetched word is held in a fetch/decode register under valid/ready handshake.
module my_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        misalign,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_out_valid;
  logic [31:0] r_out_pc;
  logic [31:0] r_out_inst;
  logic        r_misalign;
  logic [31:0] r_fetch_cnt;

  state_t      w_state;
  logic [31:0] w_pc;
  logic        w_out_valid;
  logic [31:0] w_out_pc;
  logic [31:0] w_out_inst;
  logic        w_misalign;
  logic [31:0] w_fetch_cnt;
  logic        w_hs;
  logic        w_adv;

  always_comb begin
    w_state     = r_state;
    w_pc        = r_pc;
    w_out_valid = r_out_valid;
    w_out_pc    = r_out_pc;
    w_out_inst  = r_out_inst;
    w_misalign  = r_misalign;
    w_hs        = r_out_valid && out_ready;
    w_adv       = !r_out_valid || out_ready;
    // A handshake is counted even when a redirect flushes the entry in the same cycle.
    w_fetch_cnt = r_fetch_cnt + {31'b0, w_hs};

    case (r_state)
      S_IDLE: begin
        w_out_valid = 1'b0;
        w_pc        = RESET_PC;
        if (start) w_state = S_RUN;
      end
      S_RUN: begin
        if (redirect_valid) begin
          w_out_valid = 1'b0;
          w_out_inst  = NOP_INST;
          if (redirect_pc[1:0] != 2'b00) begin
            w_state    = S_HALT;
            w_misalign = 1'b1;
          end else begin
            w_pc = redirect_pc;
          end
        end else if (w_adv) begin
          w_out_inst  = imem_inst;
          w_out_pc    = r_pc;
          w_out_valid = 1'b1;
          w_pc        = r_pc + 32'd4;
        end
      end
      S_HALT: begin
        w_out_valid = 1'b0;
      end
      default: begin
        w_state     = S_IDLE;
        w_out_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_inst  <= NOP_INST;
      r_misalign  <= 1'b0;
      r_fetch_cnt <= '0;
    end else begin
      r_state     <= w_state;
      r_pc        <= w_pc;
      r_out_valid <= w_out_valid;
      r_out_pc    <= w_out_pc;
      r_out_inst  <= w_out_inst;
      r_misalign  <= w_misalign;
      r_fetch_cnt <= w_fetch_cnt;
    end
  end

  assign imem_addr = r_pc;
  assign out_valid = r_out_valid;
  assign out_pc    = r_out_pc;
  assign out_inst  = r_out_inst;
  assign misalign  = r_misalign;
  assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_my_fetch.sv
// Bench for my_fetch: directed scenarios then random traffic against a cycle-level model.
module tb_my_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, start, redirect_valid, out_ready;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_inst, out_pc, out_inst, fetch_cnt;
  logic        out_valid, misalign;
  logic [31:0] imem_addr1, imem_inst1, out_pc1, out_inst1, fetch_cnt1;
  logic        out_valid1, misalign1;

  logic [31:0] mem [64];

  assign imem_inst  = mem[imem_addr[7:2]];
  assign imem_inst1 = mem[imem_addr1[7:2]];

  always #5 clk = ~clk;

  my_fetch #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst), .misalign(misalign),
    .fetch_cnt(fetch_cnt)
  );

  my_fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(NOP)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .imem_addr(imem_addr1), .imem_inst(imem_inst1),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid1),
    .out_ready(out_ready), .out_pc(out_pc1), .out_inst(out_inst1), .misalign(misalign1),
    .fetch_cnt(fetch_cnt1)
  );

  int unsigned nchk = 0;
  int unsigned npass = 0;

  // Reference model: mode 0 = waiting for start, 1 = fetching, 2 = halted
  int          m_mode;
  logic [31:0] m_pc, m_opc, m_inst, m_cnt;
  bit          m_valid, m_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model_next();
    if (rst) begin
      m_mode = 0; m_pc = 32'h0; m_valid = 0; m_opc = 32'h0; m_inst = NOP; m_mis = 0; m_cnt = 0;
      return;
    end
    if (m_valid && out_ready) m_cnt = m_cnt + 1;
    if (m_mode == 0) begin
      if (start) m_mode = 1;
    end else if (m_mode == 1) begin
      if (redirect_valid) begin
        m_valid = 0;
        if (redirect_pc % 4 != 0) begin
          m_mode = 2;
          m_mis  = 1;
        end else begin
          m_pc = redirect_pc;
        end
      end else if (!m_valid || out_ready) begin
        m_inst  = mem[m_pc[7:2]];
        m_opc   = m_pc;
        m_valid = 1;
        m_pc    = m_pc + 4;
      end
    end
  endtask

  task automatic check_model();
    chk("valid", {31'b0, out_valid}, {31'b0, m_valid});
    chk("imem_addr", imem_addr, m_pc);
    chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
    chk("fetch_cnt", fetch_cnt, m_cnt);
    if (m_valid) begin
      chk("out_pc", out_pc, m_opc);
      chk("out_inst", out_inst, m_inst);
    end
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    rst = 0; start = 0; redirect_valid = 0; redirect_pc = 32'h0; out_ready = 1;
  endtask

  initial begin
    foreach (mem[i]) mem[i] = $urandom;
    mem[0] = 32'h00a00093;
    mem[1] = 32'h01400113;
    mem[2] = 32'h002081b3;
    m_mode = 0; m_pc = 0; m_valid = 0; m_opc = 0; m_inst = NOP; m_mis = 0; m_cnt = 0;
    idle_inputs();

    // Reset state
    rst = 1; step(); rst = 0;
    chk("rst_out_inst", out_inst, NOP);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_wrap_addr", imem_addr1, 32'hFFFF_FFFC);
    step();
    chk("idle_no_fetch", {31'b0, out_valid}, 32'h0);

    // Basic fetch: three consecutive words
    start = 1; step(); start = 0;
    step();
    chk("basic0_pc", out_pc, 32'h0);
    chk("basic0_inst", out_inst, 32'h00a00093);
    step();
    chk("basic1_pc", out_pc, 32'h4);
    chk("basic1_inst", out_inst, 32'h01400113);
    step();
    chk("basic2_pc", out_pc, 32'h8);
    chk("basic2_inst", out_inst, 32'h002081b3);
    out_ready = 1; step();
    chk("basic_cnt", fetch_cnt, 32'd3);

    // Backpressure while holding (4, 01400113)
    rst = 1; step(); rst = 0;
    start = 1; step(); start = 0;
    step(); step();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_pc", out_pc, 32'h4);
      chk("bp_hold_inst", out_inst, 32'h01400113);
      chk("bp_hold_addr", imem_addr, 32'h8);
    end
    out_ready = 1; step();
    chk("bp_release_pc", out_pc, 32'h8);
    chk("bp_release_inst", out_inst, 32'h002081b3);

    // Redirect during a stall
    out_ready = 0; step();
    redirect_valid = 1; redirect_pc = 32'h28; step(); redirect_valid = 0;
    chk("redir_valid", {31'b0, out_valid}, 32'h0);
    chk("redir_addr", imem_addr, 32'h28);
    step();
    chk("redir_out_pc", out_pc, 32'h28);
    chk("redir_out_inst", out_inst, mem[10]);

    // Misaligned redirect halts until reset
    out_ready = 1;
    redirect_valid = 1; redirect_pc = 32'h6; step();
    chk("mis_flag", {31'b0, misalign}, 32'h1);
    redirect_pc = 32'h40; start = 1; step(); step();
    redirect_valid = 0; start = 0; step();
    chk("halt_no_fetch", {31'b0, out_valid}, 32'h0);
    rst = 1; step(); rst = 0;
    chk("mis_cleared", {31'b0, misalign}, 32'h0);

    // Reset mid-run discards the held word
    start = 1; step(); start = 0;
    step(); step();
    rst = 1; step(); rst = 0;
    chk("midrst_cnt", fetch_cnt, 32'h0);
    chk("midrst_addr", imem_addr, 32'h0);
    step(); step();
    chk("midrst_idle", {31'b0, out_valid}, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst            = ($urandom_range(0, 99) < 2);
      start          = ($urandom_range(0, 99) < 10);
      out_ready      = ($urandom_range(0, 99) < 70);
      redirect_valid = ($urandom_range(0, 99) < 12);
      redirect_pc    = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 99) < 8) redirect_pc = redirect_pc | 32'($urandom_range(1, 3));
      step();
    end

    // PC wrap on the second instance
    idle_inputs();
    rst = 1; step(); rst = 0;
    start = 1; step(); start = 0;
    step();
    chk("wrap_pc0", out_pc1, 32'hFFFF_FFFC);
    chk("wrap_inst0", out_inst1, mem[63]);
    step();
    chk("wrap_pc1", out_pc1, 32'h0000_0000);
    chk("wrap_mis", {31'b0, misalign1}, 32'h0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
